// File: rtl/ws_array_feeder.sv
// Weight-stationary array feeder: loads an NxN weight tile row by row, streams one
// activation vector into the array as gapless beats, and returns the column results.
module ws_array_feeder #(
    parameter int N = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N*8-1:0]    i_wt_data,
    input  logic              i_wt_valid,
    output logic              o_wt_ready,
    input  logic [N*8-1:0]    i_x_data,
    input  logic              i_x_valid,
    output logic              o_x_ready,
    output logic [N*16-1:0]   o_y_data,
    output logic              o_y_valid,
    input  logic              i_y_ready,
    output logic [N*8-1:0]    o_arr_w_data,
    output logic [$clog2(N)-1:0] o_arr_w_row,
    output logic              o_arr_w_load,
    output logic [7:0]        o_arr_a_data,
    output logic              o_arr_a_valid,
    input  logic              i_arr_a_ready,
    input  logic [N*16-1:0]   i_arr_c_data,
    input  logic              i_arr_c_valid,
    output logic              o_arr_c_ready,
    input  logic              i_reload,
    output logic              o_weights_loaded,
    output logic              o_busy,
    output logic              o_protocol_err
);
    localparam int RW = $clog2(N);

    generate
        if (N != 8) begin : g_bad_n
            $error("ws_array_feeder: only N=8 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        WLOAD    = 3'd0,
        IDLE     = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        OUT      = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [RW-1:0]     r_row, r_beat, r_w_row;
    logic              r_wloaded, r_w_load, r_a_valid, r_perr;
    logic [N*8-1:0]    r_w_data;
    logic [N-1:0][7:0] r_x;
    logic [N*16-1:0]   r_res;
    logic              w_wt_hs, w_x_hs, w_a_hs, w_c_hs, w_y_hs;
    logic              w_last_row, w_last_beat;

    // wt_ready is qualified by reset so every ready output reads 0 while rst_n is low,
    // yet rises the instant reset releases so the first edge can take row 0.
    assign o_wt_ready    = i_rst_n & (r_state == WLOAD);
    assign o_x_ready     = (r_state == IDLE) & r_wloaded;
    assign o_arr_c_ready = (r_state == WAIT_RES);
    assign o_y_valid     = (r_state == OUT);
    assign o_busy        = i_rst_n & (r_state != IDLE);

    assign o_arr_w_data     = r_w_data;
    assign o_arr_w_row      = r_w_row;
    assign o_arr_w_load     = r_w_load;
    assign o_arr_a_data     = r_x[r_beat];
    assign o_arr_a_valid    = r_a_valid;
    assign o_y_data         = r_res;
    assign o_weights_loaded = r_wloaded;
    assign o_protocol_err   = r_perr;

    assign w_wt_hs     = i_wt_valid & o_wt_ready;
    assign w_x_hs      = i_x_valid & o_x_ready;
    assign w_a_hs      = r_a_valid & i_arr_a_ready;
    assign w_c_hs      = i_arr_c_valid & o_arr_c_ready;
    assign w_y_hs      = o_y_valid & i_y_ready;
    assign w_last_row  = (r_row == RW'(N-1));
    assign w_last_beat = (r_beat == RW'(N-1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WLOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WLOAD:    if (w_wt_hs && w_last_row) w_state_nxt = IDLE;
            IDLE:     begin
                // A vector arriving together with reload wins; the reload is dropped.
                if (w_x_hs)        w_state_nxt = STREAM;
                else if (i_reload) w_state_nxt = WLOAD;
            end
            STREAM:   if (w_a_hs && w_last_beat) w_state_nxt = WAIT_RES;
            WAIT_RES: if (w_c_hs) w_state_nxt = OUT;
            OUT:      if (w_y_hs) w_state_nxt = IDLE;
            default:  w_state_nxt = WLOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row     <= '0;
            r_w_row   <= '0;
            r_w_data  <= '0;
            r_w_load  <= 1'b0;
            r_wloaded <= 1'b0;
        end else begin
            r_w_load <= w_wt_hs;
            if (w_wt_hs) begin
                r_w_data <= i_wt_data;
                r_w_row  <= r_row;
                r_row    <= w_last_row ? '0 : r_row + RW'(1);
                if (w_last_row) r_wloaded <= 1'b1;
            end
            if (r_state == IDLE && !w_x_hs && i_reload) r_wloaded <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x       <= '0;
            r_beat    <= '0;
            r_a_valid <= 1'b0;
            r_perr    <= 1'b0;
            r_res     <= '0;
        end else begin
            if (w_x_hs) begin
                r_x       <= i_x_data;
                r_beat    <= '0;
                r_a_valid <= 1'b1;
            end else if (w_a_hs) begin
                r_beat <= w_last_beat ? '0 : r_beat + RW'(1);
                if (w_last_beat) r_a_valid <= 1'b0;
            end
            // The array cannot tolerate a gap once the first beat has gone in.
            if (r_a_valid && !i_arr_a_ready && r_beat != '0) r_perr <= 1'b1;
            if (w_c_hs) r_res <= i_arr_c_data;
        end
    end

endmodule

// File: tb/tb_ws_array_feeder.sv
// Bench for ws_array_feeder: acts as host and as the systolic array, and checks
// results against a plain matrix-vector reference.
module tb_ws_array_feeder;
    typedef logic [7:0] mat_t [8][8];
    typedef logic [7:0] vec_t [8];

    logic         clk, rst_n;
    logic [63:0]  wt_data, x_data, arr_w_data;
    logic         wt_valid, wt_ready, x_valid, x_ready;
    logic [127:0] y_data, arr_c_data;
    logic         y_valid, y_ready;
    logic [2:0]   arr_w_row;
    logic         arr_w_load;
    logic [7:0]   arr_a_data;
    logic         arr_a_valid, arr_a_ready, arr_c_valid, arr_c_ready;
    logic         reload, weights_loaded, busy, protocol_err;

    ws_array_feeder #(.N(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wt_data(wt_data), .i_wt_valid(wt_valid), .o_wt_ready(wt_ready),
        .i_x_data(x_data), .i_x_valid(x_valid), .o_x_ready(x_ready),
        .o_y_data(y_data), .o_y_valid(y_valid), .i_y_ready(y_ready),
        .o_arr_w_data(arr_w_data), .o_arr_w_row(arr_w_row), .o_arr_w_load(arr_w_load),
        .o_arr_a_data(arr_a_data), .o_arr_a_valid(arr_a_valid), .i_arr_a_ready(arr_a_ready),
        .i_arr_c_data(arr_c_data), .i_arr_c_valid(arr_c_valid), .o_arr_c_ready(arr_c_ready),
        .i_reload(reload), .o_weights_loaded(weights_loaded), .o_busy(busy),
        .o_protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // array-side capture of weight loads and accepted activation beats
    mat_t       arr_w;
    logic [7:0] bq[$];
    int         bcyc[$];
    int         wl_row[$], wl_cyc[$];
    logic [63:0] wl_data[$];

    always @(negedge clk) begin
        if (arr_w_load) begin
            wl_row.push_back(int'(arr_w_row));
            wl_data.push_back(arr_w_data);
            wl_cyc.push_back(cyc);
            for (int k = 0; k < 8; k++) arr_w[arr_w_row][k] = arr_w_data[k*8+:8];
        end
        if (arr_a_valid && arr_a_ready) begin
            bq.push_back(arr_a_data);
            bcyc.push_back(cyc);
        end
    end

    function automatic logic [63:0] packv(input vec_t v);
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[i*8+:8] = v[i];
        return p;
    endfunction

    // C[j] = sum_i x[i] * W[i][j], signed bytes, truncated to 16 bits
    function automatic logic [127:0] mm(input mat_t w, input vec_t x);
        logic [127:0] r;
        int acc;
        for (int j = 0; j < 8; j++) begin
            acc = 0;
            for (int i = 0; i < 8; i++)
                acc += int'($signed(x[i])) * int'($signed(w[i][j]));
            r[j*16+:16] = acc[15:0];
        end
        return r;
    endfunction

    mat_t         host_w;
    bit           perr_exp;
    logic [127:0] last_y;
    int           t0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_wt_ready"}, wt_ready, 0);
        chk({pfx, "_x_ready"}, x_ready, 0);
        chk({pfx, "_y_valid"}, y_valid, 0);
        chk({pfx, "_y_data"}, y_data, 0);
        chk({pfx, "_w_load"}, arr_w_load, 0);
        chk({pfx, "_w_row"}, arr_w_row, 0);
        chk({pfx, "_w_data"}, arr_w_data, 0);
        chk({pfx, "_a_valid"}, arr_a_valid, 0);
        chk({pfx, "_a_data"}, arr_a_data, 0);
        chk({pfx, "_c_ready"}, arr_c_ready, 0);
        chk({pfx, "_wloaded"}, weights_loaded, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_perr"}, protocol_err, 0);
    endtask

    task automatic load_weights(input mat_t w, input bit gaps);
        int hs[8];
        host_w = w;
        wl_row.delete(); wl_data.delete(); wl_cyc.delete();
        for (int r = 0; r < 8; r++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            wt_valid = 1'b1;
            for (int k = 0; k < 8; k++) wt_data[k*8+:8] = w[r][k];
            @(negedge clk);
            chk("wl_wt_ready", wt_ready, 1);
            chk("wl_x_ready", x_ready, 0);
            chk("wl_loaded_early", weights_loaded, 0);
            hs[r] = cyc;
            step();
            wt_valid = 1'b0;
        end
        step();
        @(negedge clk);
        chk("wl_loaded", weights_loaded, 1);
        chk("wl_wt_ready_idle", wt_ready, 0);
        chk("wl_count", wl_row.size(), 8);
        for (int r = 0; r < 8 && r < wl_row.size(); r++) begin
            logic [63:0] expd;
            for (int k = 0; k < 8; k++) expd[k*8+:8] = w[r][k];
            chk("wl_row", wl_row[r], r);
            chk("wl_data", wl_data[r], expd);
            chk("wl_timing", wl_cyc[r], hs[r] + 1);
        end
        step();
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        @(negedge clk);
        chk("rl_wloaded", weights_loaded, 0);
        chk("rl_x_ready", x_ready, 0);
        chk("rl_wt_ready", wt_ready, 1);
        chk("rl_busy", busy, 1);
        step();
    endtask

    task automatic start_x(input vec_t x, input bit with_reload);
        int n = 0;
        while (!x_ready && n < 50) begin step(); n++; end
        chk("sx_x_ready", x_ready, 1);
        bq.delete(); bcyc.delete();
        x_valid = 1'b1;
        x_data  = packv(x);
        reload  = with_reload;
        t0 = cyc;
        step();
        x_valid = 1'b0;
        reload  = 1'b0;
        x_data  = {$urandom, $urandom};
    endtask

    task automatic send_vector(input vec_t x, input bit with_reload, input bit stall,
                               input int cdly, input int ystall);
        logic [127:0] expy;
        int k, nwl, tc;
        expy = mm(host_w, x);
        arr_a_ready = 1'b1;
        start_x(x, with_reload);
        nwl = wl_row.size();
        wt_valid = 1'b1;
        k = 1;
        while (bq.size() < 8 && k < 20) begin
            arr_a_ready = !(stall && (k == 4 || k == 5));
            @(negedge clk);
            chk("st_x_ready", x_ready, 0);
            chk("st_busy", busy, 1);
            chk("st_wt_ready", wt_ready, 0);
            chk("st_wloaded", weights_loaded, 1);
            if (stall && (k == 4 || k == 5)) chk("st_hold_data", arr_a_data, x[3]);
            if (stall && k == 5) chk("st_perr_set", protocol_err, 1);
            step();
            k++;
        end
        arr_a_ready = 1'b1;
        chk("st_beats", bq.size(), 8);
        for (int i = 0; i < 8 && i < bq.size(); i++) begin
            chk("st_beat_data", bq[i], x[i]);
            if (!stall) chk("st_beat_cyc", bcyc[i], t0 + 1 + i);
        end
        @(negedge clk);
        chk("wr_a_valid", arr_a_valid, 0);
        chk("wr_c_ready", arr_c_ready, 1);
        repeat (cdly) begin
            step();
            @(negedge clk);
            chk("wr_c_ready_hold", arr_c_ready, 1);
            chk("wr_y_valid", y_valid, 0);
        end
        step();
        begin
            vec_t bv;
            for (int i = 0; i < 8; i++) bv[i] = (i < bq.size()) ? bq[i] : 8'h00;
            arr_c_data = mm(arr_w, bv);
        end
        arr_c_valid = 1'b1;
        tc = cyc;
        step();
        arr_c_valid = 1'b0;
        arr_c_data  = {4{$urandom}};
        wt_valid    = 1'b0;
        chk("st_no_wload", wl_row.size(), nwl);
        @(negedge clk);
        chk("out_lat", cyc, tc + 1);
        repeat (ystall) begin
            chk("out_y_valid", y_valid, 1);
            chk("out_y_data", y_data, expy);
            chk("out_x_ready", x_ready, 0);
            chk("out_c_ready", arr_c_ready, 0);
            step();
            @(negedge clk);
        end
        y_ready = 1'b1;
        #1;
        chk("out_y_valid", y_valid, 1);
        chk("out_y_data", y_data, expy);
        last_y = y_data;
        step();
        y_ready = 1'b0;
        @(negedge clk);
        chk("idle_y_valid", y_valid, 0);
        chk("idle_x_ready", x_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_perr", protocol_err, perr_exp);
        step();
    endtask

    initial begin
        mat_t w;
        vec_t x;
        rst_n = 1'b0; wt_valid = 0; wt_data = '0; x_valid = 0; x_data = '0;
        y_ready = 0; arr_a_ready = 1; arr_c_valid = 0; arr_c_data = '0; reload = 0;
        perr_exp = 0;
        #3;
        chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_wt_ready", wt_ready, 1);

        // identity weights, x = 1..8
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) w[i][j] = (i == j) ? 8'd1 : 8'd0;
        load_weights(w, 0);
        for (int i = 0; i < 8; i++) x[i] = 8'(i + 1);
        send_vector(x, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) chk("ident_c", last_y[j*16+:16], 16'(j + 1));

        // all 2 x all 3
        do_reload();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) w[i][j] = 8'h02;
        load_weights(w, 1);
        for (int i = 0; i < 8; i++) x[i] = 8'h03;
        send_vector(x, 0, 0, 2, 0);
        chk("c_0030", last_y, {8{16'h0030}});

        // all FF x all 7F, host holds y_ready low 5 cycles
        do_reload();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) w[i][j] = 8'hFF;
        load_weights(w, 0);
        for (int i = 0; i < 8; i++) x[i] = 8'h7F;
        send_vector(x, 0, 0, 0, 5);
        chk("c_fc08", last_y, {8{16'hFC08}});

        // x together with reload: vector wins, weights kept
        for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
        send_vector(x, 1, 0, 1, 1);

        // gap at beat 3 sets sticky protocol_err
        for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
        perr_exp = 1;
        send_vector(x, 0, 1, 0, 0);

        // random traffic
        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_reload();
                for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) w[i][j] = 8'($urandom);
                load_weights(w, 1);
            end
            for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
            send_vector(x, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        chk("perr_sticky", protocol_err, 1);

        // reset during beat 4
        for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
        arr_a_ready = 1'b1;
        start_x(x, 0);
        repeat (4) step();
        chk("mid_beat4", arr_a_data, x[4]);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        step();
        rst_n = 1'b1;
        #1;
        chk("post_wt_ready", wt_ready, 1);
        chk("post_wloaded", weights_loaded, 0);
        chk("post_x_ready", x_ready, 0);
        chk("post_busy", busy, 1);
        perr_exp = 0;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) w[i][j] = 8'($urandom);
        load_weights(w, 0);
        for (int i = 0; i < 8; i++) x[i] = 8'($urandom);
        send_vector(x, 0, 0, 1, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
